multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control unit for the RV64I core. It is the successor to the single-cycle combinational controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using a req/ack handshake to instruction and data memory.
- Has a parametrised memory-timeout watchdog, illegal-opcode trapping and a retired-instruction counter.
- Sits between the IR/PC datapath registers and the memory interfaces. It generates all write enables that were previously implicit per clock.

Parameters:
MEM_TIMEOUT, 15, max idle wait count in FETCH/MEM before trapping; 0 disables the watchdog
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MEM_TIMEOUT
CNT_W, 32, width of the instret counter

Ports:
clk  input  1  core clock, all state updates on posedge
rstn  input  1  asynchronous active-low reset
inst  input  32  instruction from IR; stable from DECODE until next FETCH
br_taken  input  1  branch comparison result from datapath, valid in EXEC
imem_ack  input  1  instruction memory completes request this cycle
dmem_ack  input  1  data memory completes request this cycle
imem_req  output  1  instruction fetch request
dmem_req  output  1  data access request
dmem_we  output  1  data access is a write (valid with dmem_req)
ir_we  output  1  load IR from imem data
pc_we  output  1  commit next PC (PC+4 or target)
reg_we  output  1  register file write
state  output  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
halted  output  1  high in TRAP
trap_cause  output  2  0 none, 1 imem timeout, 2 illegal opcode, 3 dmem timeout
instret  output  CNT_W  retired instruction count

Behaviour:
- Reset (async, rstn=0): state=FETCH, wait_cnt=0, instret=0, trap_cause=0. All strobes are 0. imem_req is 1 after reset release, because it decodes from FETCH.
- All strobes are Moore/Mealy decodes of the current state and inputs. There are no registered strobe delays.
- Legal opcodes (inst[6:0]):
  - LOAD 0000011, STORE 0100011, BRANCH 1100011
  - JAL 1101111, JALR 1100111
  - OP-IMM 0010011, OP 0110011, OP-IMM-32 0011011, OP-32 0111011
  - LUI 0110111, AUIPC 0010111
  - All others are illegal.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1 and next state DECODE.
  - Otherwise wait_cnt++.
- DECODE (1 cycle): illegal opcode -> TRAP with cause 2; otherwise -> EXEC.
- EXEC (1 cycle):
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1, instret++, -> FETCH. Datapath selects the target when br_taken=1 and PC+4 otherwise; pc_we is asserted regardless of br_taken.
  - All other legal opcodes -> WB.
- MEM:
  - dmem_req=1 and dmem_we=(opcode==STORE).
  - On dmem_ack: LOAD -> WB; STORE -> pc_we=1, instret++, -> FETCH.
  - Otherwise wait_cnt++.
- WB (1 cycle):
  - reg_we=1 iff inst[11:7]!=0.
  - pc_we=1, instret++, -> FETCH.
- TRAP: absorbing state until reset. halted=1 and all strobes 0. trap_cause holds its value; it is written only on TRAP entry.
- Watchdog:
  - wait_cnt clears to 0 on every state transition.
  - In FETCH/MEM, if the ack is absent and MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT -> TRAP (cause 1 from FETCH, 3 from MEM).
  - This allows at most MEM_TIMEOUT+1 request cycles.
  - An ack in the same cycle as the limit is accepted; ack wins.
  - With MEM_TIMEOUT=0, wait_cnt saturates at its maximum and never traps.
- Latencies with zero-wait acks:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles
  - BRANCH: 3 cycles
  - STORE: 4 cycles
  - LOAD: 5 cycles
- instret increments exactly once per pc_we cycle and wraps modulo 2^CNT_W.
- Reset asserted mid-operation (any state, including TRAP) returns immediately to reset values. In-flight requests are dropped; memory must tolerate a dropped request.
- Acks outside the matching state are ignored.

Test Plan:
- addi x1,x0,5 (0x00500093) with immediate acks:
  - Required states: 0,1,2,4,0.
  - ir_we in cycle 1 and reg_we+pc_we in cycle 4; instret=1.
- ld x2,0(x1) with dmem_ack after 3 idle cycles:
  - dmem_req high 4 cycles with dmem_we=0, then WB with reg_we=1.
  - 8 cycles total; instret=1.
- sd x2,8(x1) (0x0020B423):
  - dmem_we=1 in MEM; after ack, pc_we=1 and go to FETCH, skipping WB.
  - reg_we never asserted.
- beq with br_taken=0, then with br_taken=1: both take 3 cycles with pc_we in EXEC; reg_we=0; instret=2.
- inst=0x00000000:
  - DECODE -> TRAP with trap_cause=2 and halted=1.
  - Stays halted for 20 further cycles even if acks are toggled.
- MEM_TIMEOUT=15, imem_ack held low:
  - TRAP after 16 request cycles with trap_cause=1.
  - Rerun with the ack on the 16th cycle: accepted, no trap.
  - rstn pulse mid-MEM: state=0, instret=0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack handshakes, memory-wait watchdog, illegal-opcode trap and instret.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      inst,
    input  logic             br_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam bit                WD_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] TMO   = WAIT_W'(MEM_TIMEOUT);

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        opcode;
    logic              is_load, is_store, is_branch, legal;
    logic              tmo_hit, wait_sat;
    logic              unused_bits;

    assign opcode    = inst[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    // Opcode legality check; everything outside the RV64I base set traps
    always_comb begin
        unique case (opcode)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_IMM, OP_OP, OP_IMM32, OP_OP32, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
    end

    assign tmo_hit  = WD_EN && (wait_cnt == TMO);
    assign wait_sat = (wait_cnt == {WAIT_W{1'b1}});

    // Strobes decode straight from state/inputs; gating with rstn keeps them
    // all low while reset is held even though the state sits in FETCH.
    assign imem_req = rstn && (st == S_FETCH);
    assign ir_we    = rstn && (st == S_FETCH) && imem_ack;
    assign dmem_req = rstn && (st == S_MEM);
    assign dmem_we  = rstn && (st == S_MEM) && is_store;
    assign reg_we   = rstn && (st == S_WB) && (inst[11:7] != 5'd0);
    assign pc_we    = rstn && (((st == S_EXEC) && is_branch) ||
                               ((st == S_MEM) && dmem_ack && is_store) ||
                               (st == S_WB));
    assign halted   = (st == S_TRAP);
    assign state    = st;

    // Branch outcome and upper instruction bits only matter to the datapath
    assign unused_bits = ^{inst[31:12], br_taken};

    // Main sequencer: state, watchdog counter and trap cause
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st         <= S_FETCH;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
        end else begin
            unique case (st)
                S_FETCH: begin
                    if (imem_ack) begin
                        st       <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (tmo_hit) begin
                        st         <= S_TRAP;
                        trap_cause <= 2'd1;
                        wait_cnt   <= '0;
                    end else if (!wait_sat) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    wait_cnt <= '0;
                    if (legal) begin
                        st <= S_EXEC;
                    end else begin
                        st         <= S_TRAP;
                        trap_cause <= 2'd2;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (is_load || is_store) st <= S_MEM;
                    else if (is_branch)      st <= S_FETCH;
                    else                     st <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        st       <= is_store ? S_FETCH : S_WB;
                        wait_cnt <= '0;
                    end else if (tmo_hit) begin
                        st         <= S_TRAP;
                        trap_cause <= 2'd3;
                        wait_cnt   <= '0;
                    end else if (!wait_sat) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    st       <= S_FETCH;
                end
                S_TRAP: begin
                    st <= S_TRAP;
                end
                default: begin
                    st       <= S_FETCH;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Retired-instruction counter: one tick per committed PC, wraps naturally
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)      instret <= '0;
        else if (pc_we) instret <= instret + 1'b1;
    end

endmodule
